// File: rtl/pwm_pkg.sv
// Shared definitions for the SPI instruction decoder: FSM state encoding
// and the bit layout of the frame setup byte.
package pwm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_DATA = 3'd1,
        RD_WAIT = 3'd2,
        RD_DATA = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int RW_BIT    = 7;
    localparam int BURST_BIT = 6;
    localparam int ADDR_LSB  = 0;

endpackage

// File: rtl/instr_dcd_burst.sv
// SPI-side instruction decoder with burst support. The first byte of a frame
// selects direction, auto-increment and start address; every following byte
// is one register access. Read data is prefetched into data_out so it is ready
// before the host shifts out the next byte.
module instr_dcd_burst
    import pwm_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int ADDR_LAST = (1 << ADDR_W) - 1,
    parameter int RD_LAT    = 1,
    parameter int BURST_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_active,
    input  logic              byte_sync,
    input  logic [7:0]        data_in,
    output logic [7:0]        data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_read,
    output logic [7:0]        data_write,
    output logic              overrun
);

    state_t     state;
    state_t     state_next;
    logic       rw;
    logic       burst;
    logic [1:0] lat_cnt;
    logic       lat_done;

    logic       load_setup;
    logic       read_next;
    logic       write_next;
    logic       rd_sample;
    logic       rd_adv;
    logic       set_ovr;

    // The cycle whose data_read must be captured is the RD_LAT-th after the read strobe.
    assign lat_done = (lat_cnt == 2'(RD_LAT));

    // Next-state and per-cycle action decode; a frame end overrides everything.
    always_comb begin
        state_next = state;
        load_setup = 1'b0;
        read_next  = 1'b0;
        write_next = 1'b0;
        rd_sample  = 1'b0;
        rd_adv     = 1'b0;
        set_ovr    = 1'b0;
        if (!frame_active) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_sync) begin
                        load_setup = 1'b1;
                        if (data_in[RW_BIT]) begin
                            state_next = WR_DATA;
                        end else begin
                            read_next  = 1'b1;
                            state_next = RD_WAIT;
                        end
                    end
                end
                WR_DATA: begin
                    if (byte_sync && rw) begin
                        write_next = 1'b1;
                        if (!burst) state_next = DONE;
                    end
                end
                RD_WAIT: begin
                    // A byte arriving here cannot be served with fresh data; it is dropped.
                    set_ovr = byte_sync;
                    if (lat_done) begin
                        rd_sample  = 1'b1;
                        state_next = RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (byte_sync && !rw) begin
                        if (burst) begin
                            rd_adv     = 1'b1;
                            read_next  = 1'b1;
                            state_next = RD_WAIT;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE: begin
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Direction and burst flags captured from the setup byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw    <= 1'b0;
            burst <= 1'b0;
        end else if (load_setup) begin
            rw    <= data_in[RW_BIT];
            burst <= data_in[BURST_BIT] && (BURST_EN != 0);
        end
    end

    // Read latency counter: restarts with every read strobe, stops once data is due.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             lat_cnt <= 2'd0;
        else if (read_next)                     lat_cnt <= 2'd0;
        else if (state == RD_WAIT && !lat_done) lat_cnt <= lat_cnt + 2'd1;
    end

    // Registered one-cycle strobes toward the register block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read  <= 1'b0;
            write <= 1'b0;
        end else begin
            read  <= read_next;
            write <= write_next;
        end
    end

    // Address load and auto-increment with wrap; burst writes advance after the strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr <= '0;
        end else if (load_setup) begin
            addr <= data_in[ADDR_LSB +: ADDR_W];
        end else if (rd_adv || (write && burst && frame_active)) begin
            addr <= (addr == ADDR_W'(ADDR_LAST)) ? '0 : addr + ADDR_W'(1);
        end
    end

    // Data capture: prefetched read data and the byte to be written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= 8'd0;
            data_write <= 8'd0;
        end else begin
            if (rd_sample)  data_out   <= data_read;
            if (write_next) data_write <= data_in;
        end
    end

    // Sticky overrun flag, cleared by the next accepted setup byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          overrun <= 1'b0;
        else if (load_setup) overrun <= 1'b0;
        else if (set_ovr)    overrun <= 1'b1;
    end

endmodule

// File: doc/instr_dcd_burst.md
Name: instr_dcd_burst

Overview:
- SPI-side instruction decoder with burst support. It sits between the SPI byte deserializer and the PWM register block.
- Each frame starts with one setup byte: bit7 = RW (1 write, 0 read), bit6 = BURST (auto-increment), bits[5:0] = start address.
- Every data byte that follows accesses one register. In burst mode the address advances after each byte until the frame ends.
- Read data is prefetched so it is ready before the host clocks out the next byte. Register read latency is configurable.

Parameters:
ADDR_W, 6, register address width, legal 1..6; header bits [5:ADDR_W] are ignored.
ADDR_LAST, 2**ADDR_W-1, highest register address; auto-increment wraps from ADDR_LAST to 0.
RD_LAT, 1, cycles from the read pulse to data_read being valid; legal 0..3.
BURST_EN, 1, 0 = BURST bit ignored, every frame is a single access.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
frame_active  in  1  high while SPI chip-select is asserted; low = frame ended
byte_sync  in  1  1-cycle pulse, data_in holds a new byte
data_in  in  8  byte received from SPI
data_out  out  8  byte for SPI to shift out on the next byte
read  out  1  1-cycle register read strobe
write  out  1  1-cycle register write strobe
addr  out  ADDR_W  register address
data_read  in  8  register read data, valid RD_LAT cycles after read
data_write  out  8  register write data
overrun  out  1  sticky: byte_sync arrived while read data was still pending

Behaviour:
- Reset: all outputs 0, state IDLE, internal rw/burst flags 0, latency counter 0. Reset mid-operation aborts any pending access; no strobe is issued afterwards.
- States and transitions:
  - IDLE: waits for byte_sync.
  - On the setup byte (byte_sync at cycle t): latch rw, burst (forced 0 if BURST_EN=0) and addr <= data_in[ADDR_W-1:0].
    - Write: go to WR_DATA.
    - Read: read=1 at t+1, go to RD_WAIT.
  - RD_WAIT: counts RD_LAT cycles after the read cycle. On the last one it samples data_read into data_out, then goes to RD_DATA.
    - With RD_LAT=0, data_read is sampled in the same cycle read is high; data_out is valid at t+2.
  - RD_DATA, on byte_sync:
    - Burst: addr advances (with wrap), read pulses in the next cycle, go to RD_WAIT.
    - No burst: go to DONE.
  - WR_DATA, on byte_sync at cycle t: data_write <= data_in and write=1 at t+1, with addr stable during the pulse.
    - Burst: addr advances at t+2, stay in WR_DATA.
    - No burst: go to DONE.
  - DONE: ignores byte_sync until the frame ends.
- Frame end (frame_active low) in any state: go to IDLE at the next edge.
  - addr, data_out and data_write hold their values.
  - overrun is cleared when the next setup byte is accepted.
  - A strobe already scheduled for the next cycle still fires.
- byte_sync together with frame_active low in the same cycle: the frame end wins and the byte is dropped.
- byte_sync in RD_WAIT: set overrun and drop the byte. The pending read completes and the state goes to RD_DATA. The host sees stale data_out for that byte.
- read and write are never high in the same cycle. Each is exactly one cycle wide per access, and back-to-back bytes produce separate pulses.
- Address arithmetic is ADDR_W bits: addr == ADDR_LAST -> 0 on increment.

Decomposition:
- Shared package (pwm_pkg):
  - state encoding localparams IDLE/WR_DATA/RD_WAIT/RD_DATA/DONE;
  - setup-byte field positions RW_BIT=7, BURST_BIT=6, ADDR_LSB=0.
- No sub-module is needed. The address-increment/wrap logic stays inline as one small always block.

Test Plan:
- Single write, setup 0x85 then 0x3C -> one write pulse with addr=5, data_write=0x3C; no further write on extra bytes; no read pulse.
- Burst write, setup 0xC3 then 0x11,0x22,0x33 -> three write pulses at addr 3,4,5 with data 0x11,0x22,0x33.
- Burst read with wrap, ADDR_LAST=63, setup 0x7F, reg63=0xAA, reg0=0x55, RD_LAT=1 -> reads at 63 then 0; data_out=0xAA before the first data byte's byte_sync, then data_out=0x55 after it.
- Overrun, RD_LAT=3, byte_sync 2 cycles after the read pulse -> overrun=1, the read still completes, and overrun clears on the next frame's setup byte.
- Frame abort, frame_active low after the setup byte 0x82 -> no write strobe; the next byte 0x40 is treated as a read setup for addr 0.
- Async reset asserted in RD_WAIT -> all outputs 0 immediately, and no read strobe or data_out update after release.
